// File: rtl/rbm_inference_sequencer.sv
// Serial schedule for the RBM classifier: one shared MAC/sigmoid datapath walks the hidden
// layer, then the classifier layer, tracking the running argmax of the class activations.
module rbm_inference_sequencer #(
    parameter int unsigned InDim           = 784,
    parameter int unsigned HDim            = 441,
    parameter int unsigned OutDim          = 10,
    parameter int unsigned OutputBitlength = 8,
    localparam int unsigned SrcMax = (InDim > HDim) ? InDim : HDim,
    localparam int unsigned DstMax = (HDim > OutDim) ? HDim : OutDim,
    localparam int unsigned SW     = (SrcMax > 1) ? $clog2(SrcMax) : 1,
    localparam int unsigned DW     = (DstMax > 1) ? $clog2(DstMax) : 1,
    localparam int unsigned CW     = (OutDim > 1) ? $clog2(OutDim) : 1
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       layer_o,
    output logic [SW-1:0]              src_addr_o,
    output logic [DW-1:0]              dst_addr_o,
    output logic                       mac_clear_o,
    output logic                       mac_en_o,
    output logic                       act_req_o,
    input  logic                       act_ack_i,
    output logic                       h_we_o,
    input  logic [OutputBitlength-1:0] score_i,
    output logic [CW-1:0]              class_idx_o,
    output logic [OutputBitlength-1:0] class_score_o
);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StAct, StWrite, StDone} state_e;

    localparam logic [SW-1:0] SrcLastHid = SW'(InDim - 1);
    localparam logic [SW-1:0] SrcLastOut = SW'(HDim - 1);
    localparam logic [DW-1:0] DstLastHid = DW'(HDim - 1);
    localparam logic [DW-1:0] DstLastOut = DW'(OutDim - 1);

    state_e                     state_q, state_d;
    logic                       layer_q, layer_d;
    logic [SW-1:0]              src_q, src_d;
    logic [DW-1:0]              dst_q, dst_d;
    logic [CW-1:0]              cls_idx_q, cls_idx_d;
    logic [OutputBitlength-1:0] cls_score_q, cls_score_d;
    logic [SW-1:0]              src_last;
    logic [DW-1:0]              dst_last;

    assign src_last = layer_q ? SrcLastOut : SrcLastHid;
    assign dst_last = layer_q ? DstLastOut : DstLastHid;

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cls_idx_d   = cls_idx_q;
        cls_score_d = cls_score_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StClear;
                    layer_d     = 1'b0;
                    src_d       = '0;
                    dst_d       = '0;
                    cls_idx_d   = '0;
                    cls_score_d = '0;
                end
            end
            StClear: begin
                src_d   = '0;
                state_d = StAccum;
            end
            StAccum: begin
                if (src_q == src_last) begin
                    state_d = StAct;
                end else begin
                    src_d = src_q + SW'(1);
                end
            end
            StAct: begin
                if (act_ack_i) begin
                    // First class always loads; strict compare keeps the lower index on ties.
                    if (layer_q && ((dst_q == '0) || (score_i > cls_score_q))) begin
                        cls_score_d = score_i;
                        cls_idx_d   = CW'(dst_q);
                    end
                    state_d = StWrite;
                end
            end
            StWrite: begin
                src_d = '0;
                if (dst_q != dst_last) begin
                    dst_d   = dst_q + DW'(1);
                    state_d = StClear;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    dst_d   = '0;
                    state_d = StClear;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            layer_q     <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            cls_idx_q   <= '0;
            cls_score_q <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cls_idx_q   <= cls_idx_d;
            cls_score_q <= cls_score_d;
        end
    end

    assign busy_o        = (state_q == StClear) || (state_q == StAccum) ||
                           (state_q == StAct) || (state_q == StWrite);
    assign done_o        = (state_q == StDone);
    assign mac_clear_o   = (state_q == StClear);
    assign mac_en_o      = (state_q == StAccum);
    assign act_req_o     = (state_q == StAct);
    assign h_we_o        = (state_q == StWrite) && !layer_q;
    assign layer_o       = layer_q;
    assign src_addr_o    = src_q;
    assign dst_addr_o    = dst_q;
    assign class_idx_o   = cls_idx_q;
    assign class_score_o = cls_score_q;

endmodule

// File: tb/tb_rbm_inference_sequencer.sv
// Directed and randomized checks of the serial RBM schedule on a small network, against a
// neuron-level model of cycle counts, write addresses and the class argmax.
module tb_rbm_inference_sequencer;

    localparam int IN  = 4;
    localparam int H   = 3;
    localparam int OUT = 3;
    localparam int OB  = 8;
    localparam int NN  = H + OUT;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          start_i = 1'b0;
    logic          act_ack_i = 1'b0;
    logic [OB-1:0] score_i = '0;
    logic          busy_o, done_o, layer_o, mac_clear_o, mac_en_o, act_req_o, h_we_o;
    logic [1:0]    src_addr_o, dst_addr_o, class_idx_o;
    logic [OB-1:0] class_score_o;

    rbm_inference_sequencer #(
        .InDim          (IN),
        .HDim           (H),
        .OutDim         (OUT),
        .OutputBitlength(OB)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .layer_o      (layer_o),
        .src_addr_o   (src_addr_o),
        .dst_addr_o   (dst_addr_o),
        .mac_clear_o  (mac_clear_o),
        .mac_en_o     (mac_en_o),
        .act_req_o    (act_req_o),
        .act_ack_i    (act_ack_i),
        .h_we_o       (h_we_o),
        .score_i      (score_i),
        .class_idx_o  (class_idx_o),
        .class_score_o(class_score_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Stimulus for one run and observations gathered during it.
    int dly[NN];
    int sc[OUT];
    int act_len[NN];
    int hwe_dst[8];
    int done_cyc, done_cnt, hwe_cnt, mac_cnt, excl_err, src_err, layer_rise, hwe_after_rst;
    longint snap;
    logic busy41, busy43;
    int idx41, idx43, score43;
    int exp_done, best;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint all_outputs();
        return longint'({busy_o, done_o, layer_o, src_addr_o, dst_addr_o, mac_clear_o,
                         mac_en_o, act_req_o, h_we_o, class_idx_o, class_score_o});
    endfunction

    // Model: each neuron costs clear + n_src accumulates + (1 + wait) activate + write.
    task automatic build_model();
        exp_done = 1;
        for (int n = 0; n < NN; n++) exp_done += ((n < H) ? IN : H) + 3 + dly[n];
        best = 0;
        for (int j = 1; j < OUT; j++) if (sc[j] > sc[best]) best = j;
    endtask

    task automatic run_seq(input logic [63:0] start_mask, input int rst_at, input int last_cyc);
        int nidx = 0, wcnt = 0, ksrc = 0, strobes;
        logic prev_layer = layer_o;
        logic rst_seen = 1'b0;
        done_cyc = -1; done_cnt = 0; hwe_cnt = 0; mac_cnt = 0; excl_err = 0; src_err = 0;
        layer_rise = 0; hwe_after_rst = 0; snap = -1;
        for (int n = 0; n < NN; n++) act_len[n] = 0;
        for (int c = 0; c <= last_cyc; c++) begin
            @(negedge clk);
            strobes = int'(mac_clear_o) + int'(mac_en_o) + int'(act_req_o) + int'(h_we_o) +
                      int'(done_o);
            if (strobes > 1) excl_err++;
            if (mac_clear_o) begin
                if (src_addr_o != 2'd0) src_err++;
                ksrc = 0;
            end
            if (mac_en_o) begin
                if (int'(src_addr_o) != ksrc) src_err++;
                ksrc++;
                mac_cnt++;
            end
            if (h_we_o) begin
                if (hwe_cnt < 8) hwe_dst[hwe_cnt] = int'(dst_addr_o);
                hwe_cnt++;
                if (layer_o) src_err++;
                if (rst_seen) hwe_after_rst++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (layer_o && !prev_layer) layer_rise++;
            prev_layer = layer_o;
            if (rst_at >= 0 && c == rst_at + 1) snap = all_outputs();
            if (c == 41) begin busy41 = busy_o; idx41 = int'(class_idx_o); end
            if (c == 43) begin
                busy43 = busy_o; idx43 = int'(class_idx_o); score43 = int'(class_score_o);
            end
            // Drive next-cycle inputs.
            start_i = (c < 64) ? start_mask[c] : 1'b0;
            reset_i = (c == rst_at);
            if (reset_i) rst_seen = 1'b1;
            if (act_req_o) begin
                if (nidx >= NN || wcnt == dly[nidx]) begin
                    act_ack_i = 1'b1;
                    score_i = (nidx >= H && nidx < NN) ? OB'(sc[nidx-H]) : OB'($urandom);
                    if (nidx < NN) act_len[nidx] = wcnt + 1;
                    nidx++;
                    wcnt = 0;
                end else begin
                    act_ack_i = 1'b0;
                    score_i = OB'($urandom);
                    wcnt++;
                end
            end else begin
                act_ack_i = 1'($urandom);
                score_i = OB'($urandom);
            end
        end
        start_i = 1'b0;
        reset_i = 1'b0;
        act_ack_i = 1'b0;
    endtask

    task automatic check_full(input string tag);
        check({tag, " done cycle"}, done_cyc, exp_done);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " h_we count"}, hwe_cnt, H);
        for (int i = 0; i < H; i++) check({tag, " h_we dst"}, hwe_dst[i], i);
        check({tag, " mac_en count"}, mac_cnt, H * IN + OUT * H);
        check({tag, " strobe exclusivity"}, excl_err, 0);
        check({tag, " src sequence"}, src_err, 0);
        check({tag, " layer rises"}, layer_rise, 1);
        for (int n = 0; n < NN; n++) check({tag, " act_req length"}, act_len[n], dly[n] + 1);
        check({tag, " class_idx"}, class_idx_o, best);
        check({tag, " class_score"}, class_score_o, sc[best]);
        check({tag, " busy after"}, busy_o, 0);
    endtask

    initial begin
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        check("reset outputs", all_outputs(), 0);
        reset_i = 1'b0;
        @(negedge clk);

        // Immediate acks, tie between classes 1 and 2.
        for (int n = 0; n < NN; n++) dly[n] = 0;
        sc[0] = 5; sc[1] = 9; sc[2] = 9;
        build_model();
        check("model small done", exp_done, 40);
        run_seq(64'd1, -1, exp_done + 2);
        check_full("argmax tie");

        sc[0] = 0; sc[1] = 0; sc[2] = 0;
        build_model();
        run_seq(64'd1, -1, exp_done + 2);
        check_full("argmax zero");

        // Three-cycle ack stall on hidden neuron 1.
        dly[1] = 3;
        sc[0] = 200; sc[1] = 17; sc[2] = 255;
        build_model();
        run_seq(64'd1, -1, exp_done + 2);
        check_full("stall");
        check("stall done cycle 43", done_cyc, 43);
        dly[1] = 0;

        // Start pulses mid-run and in DONE are ignored; start in IDLE begins a new run.
        sc[0] = 3; sc[1] = 7; sc[2] = 2;
        build_model();
        run_seq(64'd1 | (64'd1 << 5) | (64'd1 << 20) | (64'd1 << 40) | (64'd1 << 42), -1, 43);
        check("gating done cycle", done_cyc, 40);
        check("gating done pulses", done_cnt, 1);
        check("gating h_we count", hwe_cnt, H);
        check("gating idle after done", busy41, 0);
        check("gating class held", idx41, 1);
        check("gating restart busy", busy43, 1);
        check("gating restart idx cleared", idx43, 0);
        check("gating restart score cleared", score43, 0);
        reset_i = 1'b1;
        @(negedge clk);
        check("reset from restart", all_outputs(), 0);
        reset_i = 1'b0;

        // Reset in the accumulate phase of hidden neuron 2 (cycles 16..19).
        run_seq(64'd1, 17, 30);
        check("mid reset outputs", snap, 0);
        check("mid reset h_we before", hwe_cnt, 2);
        check("mid reset h_we after", hwe_after_rst, 0);
        check("mid reset no done", done_cnt, 0);
        sc[0] = 1; sc[1] = 2; sc[2] = 3;
        build_model();
        run_seq(64'd1, -1, exp_done + 2);
        check_full("after reset");

        // Randomized ack latencies and scores (coarse values so ties occur).
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NN; n++) dly[n] = int'($urandom_range(0, 3));
            for (int j = 0; j < OUT; j++) sc[j] = 60 * int'($urandom_range(0, 4));
            build_model();
            run_seq(64'd1, -1, exp_done + 2);
            check_full("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
